axis_traffic_generator: RTL and testbench

// AXI4-Stream source that emits a deterministic data pattern to feed a

---
 rtl/axis_traffic_generator.sv | 106 ++++++++++
 tb/tb_axis_traffic_generator.sv | 124 ++++++++++++
 2 files changed

// File: rtl/axis_traffic_generator.sv
// axis_traffic_generator: AXI4-Stream source emitting a counter or LFSR pattern with optional finite bursts and idle gaps
//
// Ports:
//   clk          clock, rising-edge
//   rst          asynchronous reset, active-high
//   axis_tdata   registered stream data
//   axis_tvalid  registered stream valid
//   axis_tready  sink ready
//
// Build option: define TRAFFIC_GEN_LFSR_EN to source data from a 64-bit Fibonacci
// LFSR (x^64+x^63+x^61+x^60+1) instead of an incrementing counter.
module axis_traffic_generator #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned NUM_BEATS   = 0,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter logic [63:0] START_VALUE = 64'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] axis_tdata,
  output logic                  axis_tvalid,
  input  logic                  axis_tready
);
  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d, next_data, first_data;
  logic                  tvalid_q, tvalid_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;
  logic [31:0]           gap_cnt_q, gap_cnt_d;
  logic                  hs;
  assign hs = tvalid_q && axis_tready;
`ifdef TRAFFIC_GEN_LFSR_EN
  localparam logic [63:0] SEED = (START_VALUE == 64'd0) ? 64'd1 : START_VALUE;
  logic [63:0] lfsr_q, lfsr_d, lfsr_next;
  // Feedback from taps 64,63,61,60 enters bit 0; a non-zero seed can never reach the all-zero state.
  assign lfsr_next  = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
  assign next_data  = lfsr_next[DATA_WIDTH-1:0];
  assign first_data = SEED[DATA_WIDTH-1:0];
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == INIT) lfsr_d = SEED;
    else if (state_q == SEND && hs) lfsr_d = lfsr_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 64'd0;
    else lfsr_q <= lfsr_d;
  end
`else
  assign next_data  = tdata_q + DATA_WIDTH'(1);
  assign first_data = START_VALUE[DATA_WIDTH-1:0];
`endif
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      INIT: begin
        state_d  = SEND;
        tvalid_d = 1'b1;
        tdata_d  = first_data;
      end
      SEND: if (hs) begin
        beat_cnt_d = beat_cnt_q + 32'd1;
        if (NUM_BEATS != 0 && beat_cnt_d == NUM_BEATS) begin
          state_d  = DONE;
          tvalid_d = 1'b0;
        end else if (GAP_CYCLES == 0) begin
          tdata_d = next_data;
        end else begin
          state_d   = GAP;
          tvalid_d  = 1'b0;
          tdata_d   = next_data;
          gap_cnt_d = 32'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        state_d   = (gap_cnt_q == 32'd0) ? SEND : GAP;
        tvalid_d  = (gap_cnt_q == 32'd0);
        gap_cnt_d = (gap_cnt_q == 32'd0) ? gap_cnt_q : gap_cnt_q - 32'd1;
      end
      default: tvalid_d = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      beat_cnt_q <= 32'd0;
      gap_cnt_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end
  assign axis_tdata  = tdata_q;
  assign axis_tvalid = tvalid_q;
endmodule

// File: tb/tb_axis_traffic_generator.sv
// tb_axis_traffic_generator: directed table-driven bench for axis_traffic_generator
module tb_axis_traffic_generator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tr0 = 1'b0, tr1 = 1'b1, tr2 = 1'b1;
  logic [63:0] d0, d1;
  logic [7:0]  d2;
  logic        v0, v1, v2;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  axis_traffic_generator u0 (.clk(clk), .rst(rst), .axis_tdata(d0), .axis_tvalid(v0), .axis_tready(tr0));
  axis_traffic_generator #(.NUM_BEATS(4), .GAP_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .axis_tdata(d1), .axis_tvalid(v1), .axis_tready(tr1));
  axis_traffic_generator #(.DATA_WIDTH(8), .START_VALUE(64'hFE)) u2 (
    .clk(clk), .rst(rst), .axis_tdata(d2), .axis_tvalid(v2), .axis_tready(tr2));
  typedef struct {
    logic        tr;
    logic        v0;
    logic [63:0] d0;
    logic        v1;
    logic [63:0] d1;
    logic [7:0]  d2;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction
  initial begin
    tbl[0]  = '{1'b0, 1'b1, 64'd0, 1'b1, 64'd0, 8'hFE};
    tbl[1]  = '{1'b0, 1'b1, 64'd0, 1'b0, 64'd1, 8'hFF};
    tbl[2]  = '{1'b0, 1'b1, 64'd0, 1'b0, 64'd1, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 64'd0, 1'b1, 64'd1, 8'h01};
    tbl[4]  = '{1'b0, 1'b1, 64'd0, 1'b0, 64'd2, 8'h02};
    tbl[5]  = '{1'b0, 1'b1, 64'd0, 1'b0, 64'd2, 8'h03};
    tbl[6]  = '{1'b1, 1'b1, 64'd1, 1'b1, 64'd2, 8'h04};
    tbl[7]  = '{1'b1, 1'b1, 64'd2, 1'b0, 64'd3, 8'h05};
    tbl[8]  = '{1'b0, 1'b1, 64'd2, 1'b0, 64'd3, 8'h06};
    tbl[9]  = '{1'b1, 1'b1, 64'd3, 1'b1, 64'd3, 8'h07};
    tbl[10] = '{1'b1, 1'b1, 64'd4, 1'b0, 64'd3, 8'h08};
    tbl[11] = '{1'b1, 1'b1, 64'd5, 1'b0, 64'd3, 8'h09};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tr0 = i[0];
      tr1 = ~i[0];
      tr2 = i[0];
      @(posedge clk);
      #1;
      chk($sformatf("rst_v0[%0d]", i), {63'd0, v0}, 64'd0);
      chk($sformatf("rst_d0[%0d]", i), d0, 64'd0);
      chk($sformatf("rst_v1[%0d]", i), {63'd0, v1}, 64'd0);
      chk($sformatf("rst_d1[%0d]", i), d1, 64'd0);
      chk($sformatf("rst_v2[%0d]", i), {63'd0, v2}, 64'd0);
      chk($sformatf("rst_d2[%0d]", i), {56'd0, d2}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tr1 = 1'b1;
    tr2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tr0 = tbl[i].tr;
      @(posedge clk);
      #1;
      chk($sformatf("v0[%0d]", i), {63'd0, v0}, {63'd0, tbl[i].v0});
      chk($sformatf("v1[%0d]", i), {63'd0, v1}, {63'd0, tbl[i].v1});
      chk($sformatf("v2[%0d]", i), {63'd0, v2}, 64'd1);
`ifndef TRAFFIC_GEN_LFSR_EN
      chk($sformatf("d0[%0d]", i), d0, tbl[i].d0);
      chk($sformatf("d1[%0d]", i), d1, tbl[i].d1);
      chk($sformatf("d2[%0d]", i), {56'd0, d2}, {56'd0, tbl[i].d2});
`endif
      @(negedge clk);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_v0", {63'd0, v0}, 64'd0);
    chk("async_v2", {63'd0, v2}, 64'd0);
    chk("async_d2", {56'd0, d2}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tr0 = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_v2", {63'd0, v2}, 64'd1);
    chk("restart_d2", {56'd0, d2}, 64'hFE);
`ifndef TRAFFIC_GEN_LFSR_EN
    @(posedge clk);
    #1;
    chk("restart_d2_next", {56'd0, d2}, 64'hFF);
    chk("restart_d0_next", d0, 64'd1);
`endif
`ifdef TRAFFIC_GEN_LFSR_EN
    begin
      logic [63:0] m;
      @(negedge clk);
      rst = 1'b1;
      tr0 = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m = 64'd1;
      @(posedge clk);
      #1;
      chk("lfsr[0]", d0, m);
      for (int i = 1; i < 1000; i++) begin
        m = lfsr_step(m);
        @(posedge clk);
        #1;
        chk($sformatf("lfsr[%0d]", i), d0, m);
        chk($sformatf("lfsr_nz[%0d]", i), {63'd0, d0 != 64'd0}, 64'd1);
      end
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
